mbi_cfg_seq: RTL and testbench

MBI_CFG_SEQ -- requirements
Module: mbi_cfg_seq

---
 rtl/mbi_cfg_seq.sv | 130 +++++++++++++
 tb/tb_mbi_cfg_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbi_cfg_seq.sv
// mbi_cfg_seq: programs NUM_CFG LED-driver config words as PREA/RCFG command pairs with timeout, retry and abort
module mbi_cfg_seq #(
  parameter int NUM_CFG     = 3,
  parameter int ADDR_W      = 3,
  parameter int PREA_EN     = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQUEST_IN,
  input  logic              ABORT,
  input  logic              IF_READY,
  input  logic              CMD_DONE,
  output logic [ADDR_W-1:0] CFG_WORD_ADDR,
  output logic              REQUEST_TO_SEND_PREA_CMD,
  output logic              REQUEST_TO_SEND_RCFG_CMD,
  output logic              READY,
  output logic              ACTIVE,
  output logic              DONE,
  output logic              ERROR,
  output logic [3:0]        RETRY_CNT
);
  localparam int WW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_CFG - 1);
  localparam logic [WW-1:0]     TMO_LAST = WW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  localparam logic [RW-1:0]     RMAX     = RW'(MAX_RETRY);
  typedef enum logic [2:0] {
    S_IDLE, S_PREA, S_WAIT_PREA, S_RCFG, S_WAIT_RCFG, S_DONE, S_FAIL
  } state_t;
  localparam state_t S_START = PREA_EN != 0 ? S_PREA : S_RCFG;
  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [WW-1:0]     r_wait_cnt;
  logic [RW-1:0]     r_retry_reg;
  logic [3:0]        r_retry_cnt;
  logic              r_prea;
  logic              r_rcfg;
  logic              r_ready;
  logic              r_active;
  logic              r_done;
  logic              r_error;
  logic              w_tmo;
  assign w_tmo                    = (TIMEOUT_CYC != 0) && (r_wait_cnt == TMO_LAST);
  assign CFG_WORD_ADDR            = r_idx;
  assign REQUEST_TO_SEND_PREA_CMD = r_prea;
  assign REQUEST_TO_SEND_RCFG_CMD = r_rcfg;
  assign READY                    = r_ready;
  assign ACTIVE                   = r_active;
  assign DONE                     = r_done;
  assign ERROR                    = r_error;
  assign RETRY_CNT                = r_retry_cnt;
  // sequencer: walks the index down from NUM_CFG-1, one command pair per word; abort beats done/timeout, done beats timeout
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_idx       <= LAST;
      r_wait_cnt  <= '0;
      r_retry_reg <= '0;
      r_retry_cnt <= '0;
      r_prea      <= 1'b0;
      r_rcfg      <= 1'b0;
      r_ready     <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_prea <= 1'b0;
      r_rcfg <= 1'b0;
      r_done <= 1'b0;
      if (ABORT && r_state != S_IDLE) begin
        r_state  <= S_IDLE;
        r_ready  <= 1'b1;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (REQUEST_IN) begin
            r_state     <= S_START;
            r_ready     <= 1'b0;
            r_active    <= 1'b1;
            r_idx       <= LAST;
            r_error     <= 1'b0;
            r_retry_cnt <= '0;
            r_retry_reg <= '0;
          end
          S_PREA: if (IF_READY) begin
            r_prea     <= 1'b1;
            r_state    <= S_WAIT_PREA;
            r_wait_cnt <= '0;
          end
          S_RCFG: if (IF_READY) begin
            r_rcfg     <= 1'b1;
            r_state    <= S_WAIT_RCFG;
            r_wait_cnt <= '0;
          end
          S_WAIT_PREA, S_WAIT_RCFG: begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
            if (CMD_DONE) begin
              if (r_state == S_WAIT_PREA) r_state <= S_RCFG;
              else if (r_idx != '0) begin
                r_idx       <= r_idx - ADDR_W'(1);
                r_retry_reg <= '0;
                r_state     <= S_START;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else if (w_tmo) begin
              if (r_retry_reg < RMAX) begin
                r_retry_reg <= r_retry_reg + RW'(1);
                r_retry_cnt <= r_retry_cnt + {3'b0, r_retry_cnt != 4'hF};
                r_state     <= S_START;
              end else begin
                r_state <= S_FAIL;
                r_error <= 1'b1;
              end
            end
          end
          S_DONE, S_FAIL: begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_active <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mbi_cfg_seq.sv
// tb_mbi_cfg_seq: directed vector table plus multi-cycle sequences on three parameterisations of mbi_cfg_seq
module tb_mbi_cfg_seq;
  typedef struct packed {
    logic req, abt, ifr, cd;
    logic rdy, act, prea, rcfg, dn, err;
    logic [2:0] addr;
  } vec_t;
  logic CLK, RESET, req, abt, ifr, man_cd, auto_mode;
  logic rdy_o[3], act_o[3], prea_o[3], rcfg_o[3], done_o[3], err_o[3], cd[3], auto_cd[3];
  logic [2:0] addr_o[3];
  logic [3:0] rcnt_o[3];
  int cnt[3], dcount[3];
  int mute[3] = '{-1, -1, 1};
  int focus = 0;
  int total = 0;
  int bad = 0;
  logic [3:0] lg[$];
  logic [3:0] eq[$];
  vec_t tbl[$];
  logic seen;
  mbi_cfg_seq u_a (
    .CLK(CLK), .RESET(RESET), .REQUEST_IN(req), .ABORT(abt), .IF_READY(ifr), .CMD_DONE(cd[0]),
    .CFG_WORD_ADDR(addr_o[0]), .REQUEST_TO_SEND_PREA_CMD(prea_o[0]), .REQUEST_TO_SEND_RCFG_CMD(rcfg_o[0]),
    .READY(rdy_o[0]), .ACTIVE(act_o[0]), .DONE(done_o[0]), .ERROR(err_o[0]), .RETRY_CNT(rcnt_o[0]));
  mbi_cfg_seq #(.NUM_CFG(4), .PREA_EN(0)) u_b (
    .CLK(CLK), .RESET(RESET), .REQUEST_IN(req), .ABORT(abt), .IF_READY(ifr), .CMD_DONE(cd[1]),
    .CFG_WORD_ADDR(addr_o[1]), .REQUEST_TO_SEND_PREA_CMD(prea_o[1]), .REQUEST_TO_SEND_RCFG_CMD(rcfg_o[1]),
    .READY(rdy_o[1]), .ACTIVE(act_o[1]), .DONE(done_o[1]), .ERROR(err_o[1]), .RETRY_CNT(rcnt_o[1]));
  mbi_cfg_seq #(.TIMEOUT_CYC(16)) u_c (
    .CLK(CLK), .RESET(RESET), .REQUEST_IN(req), .ABORT(abt), .IF_READY(ifr), .CMD_DONE(cd[2]),
    .CFG_WORD_ADDR(addr_o[2]), .REQUEST_TO_SEND_PREA_CMD(prea_o[2]), .REQUEST_TO_SEND_RCFG_CMD(rcfg_o[2]),
    .READY(rdy_o[2]), .ACTIVE(act_o[2]), .DONE(done_o[2]), .ERROR(err_o[2]), .RETRY_CNT(rcnt_o[2]));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always_comb for (int k = 0; k < 3; k++) cd[k] = auto_mode ? auto_cd[k] : man_cd;
  // command-interface model: answers each request with a CMD_DONE strobe 5 cycles later, logs requests and DONE pulses
  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      auto_cd[k] = 1'b0;
      if (RESET) begin
        cnt[k] = 0;
        dcount[k] = 0;
        lg.delete();
      end else if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) auto_cd[k] = 1'b1;
      end
      if (prea_o[k] || rcfg_o[k]) begin
        if (k == focus) lg.push_back({rcfg_o[k], addr_o[k]});
        if (int'(addr_o[k]) != mute[k]) cnt[k] = 5;
      end
      if (done_o[k]) dcount[k]++;
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic chk_log(input string nm);
    chk({nm, "_len"}, lg.size(), eq.size());
    for (int i = 0; i < eq.size(); i++)
      chk($sformatf("%s_%0d", nm, i), i < lg.size() ? {28'b0, lg[i]} : 32'hx, {28'b0, eq[i]});
  endtask
  task automatic step(input logic r, input logic a, input logic i, input logic c);
    @(negedge CLK);
    req = r; abt = a; ifr = i; man_cd = c;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset;
    @(negedge CLK);
    RESET = 1'b1; req = 1'b0; abt = 1'b0; ifr = 1'b0; man_cd = 1'b0; auto_mode = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask
  task automatic start_auto;
    @(negedge CLK);
    auto_mode = 1'b1; ifr = 1'b1; req = 1'b1;
    @(negedge CLK);
    req = 1'b0;
  endtask
  task automatic wait_done(input int k);
    for (int c = 0; c < 400; c++) begin
      @(posedge CLK);
      #1;
      if (dcount[k] != 0) break;
    end
  endtask
  task automatic run_fail;
    do_reset;
    focus = 2;
    start_auto;
    for (int c = 0; c < 800; c++) begin
      @(posedge CLK);
      #1;
      if (err_o[2]) break;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl.push_back(13'b1_0_0_0_0_1_0_0_0_0_010);
    tbl.push_back(13'b0_0_0_0_0_1_0_0_0_0_010);
    tbl.push_back(13'b0_0_1_0_0_1_1_0_0_0_010);
    tbl.push_back(13'b0_0_1_0_0_1_0_0_0_0_010);
    tbl.push_back(13'b0_0_1_1_0_1_0_0_0_0_010);
    tbl.push_back(13'b0_0_1_0_0_1_0_1_0_0_010);
    tbl.push_back(13'b0_0_1_1_0_1_0_0_0_0_001);
    tbl.push_back(13'b0_0_1_0_0_1_1_0_0_0_001);
    tbl.push_back(13'b0_0_1_1_0_1_0_0_0_0_001);
    tbl.push_back(13'b0_0_1_0_0_1_0_1_0_0_001);
    tbl.push_back(13'b1_0_1_1_0_1_0_0_0_0_000);
    tbl.push_back(13'b0_0_1_0_0_1_1_0_0_0_000);
    tbl.push_back(13'b0_0_1_1_0_1_0_0_0_0_000);
    tbl.push_back(13'b0_0_1_0_0_1_0_1_0_0_000);
    tbl.push_back(13'b0_0_1_1_0_1_0_0_1_0_000);
    tbl.push_back(13'b0_0_1_0_1_0_0_0_0_0_000);
    tbl.push_back(13'b0_0_1_1_1_0_0_0_0_0_000);
    tbl.push_back(13'b0_1_1_0_1_0_0_0_0_0_000);
    RESET = 1'b1; req = 1'b0; abt = 1'b0; ifr = 1'b0; man_cd = 1'b0; auto_mode = 1'b0;
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state_%0d", k),
          {rdy_o[k], act_o[k], done_o[k], err_o[k], prea_o[k], rcfg_o[k], rcnt_o[k], addr_o[k]},
          {6'b100000, 4'd0, k == 1 ? 3'd3 : 3'd2});
    RESET = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].abt, tbl[i].ifr, tbl[i].cd);
      chk($sformatf("tbl_%0d", i),
          {rdy_o[0], act_o[0], prea_o[0], rcfg_o[0], done_o[0], err_o[0], addr_o[0]},
          {tbl[i].rdy, tbl[i].act, tbl[i].prea, tbl[i].rcfg, tbl[i].dn, tbl[i].err, tbl[i].addr});
    end
    do_reset;
    focus = 0;
    start_auto;
    wait_done(0);
    chk("seq3_done_seen", dcount[0], 1);
    chk("seq3_idle_after_done", {rdy_o[0], act_o[0], done_o[0]}, 3'b100);
    eq = '{4'h2, 4'hA, 4'h1, 4'h9, 4'h0, 4'h8};
    chk_log("seq3_log");
    repeat (5) @(posedge CLK);
    #1;
    chk("seq3_single_done", dcount[0], 1);
    do_reset;
    focus = 1;
    start_auto;
    wait_done(1);
    chk("seq4_done_seen", dcount[1], 1);
    chk("seq4_idle_after_done", {rdy_o[1], act_o[1]}, 2'b10);
    eq = '{4'hB, 4'hA, 4'h9, 4'h8};
    chk_log("seq4_log");
    do_reset;
    step(1, 0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 0);
      seen = seen | prea_o[0] | rcfg_o[0];
    end
    chk("stall_no_req", seen, 0);
    chk("stall_active", {act_o[0], addr_o[0]}, {1'b1, 3'd2});
    step(0, 0, 1, 0);
    chk("stall_release_prea", {prea_o[0], rcfg_o[0], addr_o[0]}, {2'b10, 3'd2});
    run_fail;
    chk("tmo_error", err_o[2], 1);
    chk("tmo_retry_cnt", rcnt_o[2], 2);
    chk("tmo_in_fail", {rdy_o[2], act_o[2], done_o[2]}, 3'b010);
    chk("tmo_no_done", dcount[2], 0);
    eq = '{4'h2, 4'hA, 4'h1, 4'h1, 4'h1};
    chk_log("tmo_log");
    step(0, 0, 1, 0);
    chk("fail_to_idle", {rdy_o[2], act_o[2], err_o[2]}, 3'b101);
    repeat (5) step(0, 0, 1, 0);
    chk("error_holds", {err_o[2], rcnt_o[2], dcount[2][3:0]}, {1'b1, 4'd2, 4'd0});
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_clears_err", {err_o[2], rcnt_o[2], rdy_o[2], addr_o[2]}, {1'b0, 4'd0, 1'b1, 3'd2});
    @(negedge CLK);
    RESET = 1'b0;
    run_fail;
    chk("tmo2_error", err_o[2], 1);
    repeat (3) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("req_clears_err", {err_o[2], rcnt_o[2], act_o[2]}, {1'b0, 4'd0, 1'b1});
    do_reset;
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("rst_mid_wait_prea", {prea_o[0], addr_o[0]}, {1'b1, 3'd1});
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("rst_async_state", {rdy_o[0], act_o[0], prea_o[0], rcfg_o[0], done_o[0], addr_o[0]}, {5'b10000, 3'd2});
    @(negedge CLK);
    RESET = 1'b0;
    step(1, 0, 0, 0);
    chk("rst_restart_accept", {rdy_o[0], act_o[0], addr_o[0]}, {2'b01, 3'd2});
    step(0, 0, 1, 0);
    chk("rst_restart_prea", {prea_o[0], addr_o[0], dcount[0][3:0]}, {1'b1, 3'd2, 4'd0});
    do_reset;
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("abort_setup_rcfg", {rcfg_o[0], addr_o[0]}, {1'b1, 3'd1});
    step(0, 1, 1, 1);
    chk("abort_to_idle", {rdy_o[0], act_o[0], prea_o[0], rcfg_o[0], done_o[0], err_o[0]}, 6'b100000);
    repeat (4) step(0, 0, 1, 0);
    chk("abort_quiet", {rdy_o[0], act_o[0], err_o[0], dcount[0][3:0]}, {3'b100, 4'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
